// File: rtl/mouse_event_tracker.sv
// mouse_event_tracker: registers the decoder's binned cursor/buttons, runs a
// moving/settling/idle motion state machine, and queues every button press
// (position + press mask) in a show-ahead event FIFO with a sticky overflow.
module mouse_event_tracker #(
    parameter int COORD_W    = 4,
    parameter int NUM_BTN    = 3,
    parameter int SETTLE     = 1000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [COORD_W-1:0]              x_in,
    input  logic [COORD_W-1:0]              y_in,
    input  logic [NUM_BTN-1:0]              btn_in,
    input  logic                            ev_ready,
    input  logic                            clr_overflow,
    output logic                            ev_valid,
    output logic [COORD_W-1:0]              ev_x,
    output logic [COORD_W-1:0]              ev_y,
    output logic [NUM_BTN-1:0]              ev_btn,
    output logic                            moving,
    output logic                            motion_pulse,
    output logic [$clog2(FIFO_DEPTH):0]     ev_count,
    output logic                            overflow
);

    localparam int CNT_W = $clog2(SETTLE);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int EC_W  = PTR_W + 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MOVING   = 2'd1;
    localparam logic [1:0] SETTLING = 2'd2;

    typedef struct packed {
        logic [NUM_BTN-1:0] btn;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } entry_t;

    logic [COORD_W-1:0] x_q, y_q, x_p, y_p;
    logic [NUM_BTN-1:0] btn_q, btn_p;
    logic               primed;
    logic               change;
    logic [NUM_BTN-1:0] press;
    logic               push;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;

    entry_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               full, pop, wr_en, drop;
    entry_t             head;

    // Input stage: capture decoder outputs every cycle.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q   <= '0;
            y_q   <= '0;
            btn_q <= '0;
        end else begin
            x_q   <= x_in;
            y_q   <= y_in;
            btn_q <= btn_in;
        end
    end

    // Compare stage: the prime edge loads the value the input stage captures on
    // that same edge, so the first compare sees no spurious change or press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_p    <= '0;
            y_p    <= '0;
            btn_p  <= '0;
            primed <= 1'b0;
        end else if (!primed) begin
            x_p    <= x_in;
            y_p    <= y_in;
            btn_p  <= btn_in;
            primed <= 1'b1;
        end else begin
            x_p    <= x_q;
            y_p    <= y_q;
            btn_p  <= btn_q;
        end
    end

    // Change and press detection, suppressed until primed.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        change = 1'b0;
        press  = '0;
        if (primed) begin
            change = (x_q != x_p) || (y_q != y_p);
            press  = btn_q & ~btn_p;
        end
    end

    assign push = |press;

    // Motion FSM: IDLE -> MOVING on change (with pulse); SETTLE quiet edges to return.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            motion_pulse <= 1'b0;
        end else begin
            motion_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (change) begin
                        state        <= MOVING;
                        motion_pulse <= 1'b1;
                    end
                end
                MOVING: begin
                    if (!change) begin
                        state <= SETTLING;
                        cnt   <= CNT_W'(1);
                    end
                end
                SETTLING: begin
                    if (change) begin
                        state <= MOVING;
                    end else if (cnt == CNT_W'(SETTLE - 1)) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign moving = (state != IDLE);

    assign full  = (ev_count == EC_W'(FIFO_DEPTH));
    assign pop   = ev_valid && ev_ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    // Event FIFO storage, pointers and occupancy.
    // NOTE: the storage is reset too, so the head fields read 0 out of reset;
    // the array is small enough that this costs little.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ev_count <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= '{btn: press, y: y_q, x: x_q};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   ev_count <= ev_count + EC_W'(1);
                2'b01:   ev_count <= ev_count - EC_W'(1);
                default: ev_count <= ev_count;
            endcase
        end
    end

    // Sticky overflow: a same-cycle drop wins over the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
        else if (clr_overflow) overflow <= 1'b0;
    end

    assign head     = mem[rd_ptr];
    assign ev_valid = (ev_count != '0);
    assign ev_x     = head.x;
    assign ev_y     = head.y;
    assign ev_btn   = head.btn;

endmodule

// File: tb/tb_mouse_event_tracker.sv
// Directed bench for mouse_event_tracker (SETTLE = 4, FIFO_DEPTH = 8).
module tb_mouse_event_tracker;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] x_in, y_in;
    logic [2:0] btn_in;
    logic       ev_ready, clr_overflow;
    logic       ev_valid, moving, motion_pulse, overflow;
    logic [3:0] ev_x, ev_y;
    logic [2:0] ev_btn;
    logic [3:0] ev_count;

    int n_cmp = 0;
    int n_bad = 0;

    mouse_event_tracker #(
        .COORD_W(4), .NUM_BTN(3), .SETTLE(4), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .x_in(x_in), .y_in(y_in), .btn_in(btn_in),
        .ev_ready(ev_ready), .clr_overflow(clr_overflow), .ev_valid(ev_valid),
        .ev_x(ev_x), .ev_y(ev_y), .ev_btn(ev_btn), .moving(moving),
        .motion_pulse(motion_pulse), .ev_count(ev_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; x_in = 4'd5; y_in = 4'd3; btn_in = 3'b000;
        ev_ready = 1'b0; clr_overflow = 1'b0;
        #1;
        n_cmp++;
        if ({ev_valid, ev_x, ev_y, ev_btn, moving, motion_pulse, ev_count, overflow} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b x=%0d y=%0d b=%b mv=%b mp=%b cnt=%0d ov=%b want all 0",
                     ev_valid, ev_x, ev_y, ev_btn, moving, motion_pulse, ev_count, overflow);
        end
        step(); step();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (motion_pulse !== 1'b0 || moving !== 1'b0) begin
                n_bad++;
                $display("FAIL prime_no_motion[%0d]: got mp=%b mv=%b want 0 0", i, motion_pulse, moving);
            end
        end
    endtask

    task automatic test_motion();
        x_in = 4'd6;
        step();
        n_cmp++;
        if (moving !== 1'b0 || motion_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL motion_latency: got mv=%b mp=%b want 0 0", moving, motion_pulse);
        end
        step();
        n_cmp++;
        if (moving !== 1'b1 || motion_pulse !== 1'b1) begin
            n_bad++;
            $display("FAIL motion_start: got mv=%b mp=%b want 1 1", moving, motion_pulse);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            n_cmp++;
            if (moving !== (i < 4) || motion_pulse !== 1'b0) begin
                n_bad++;
                $display("FAIL settle[%0d]: got mv=%b mp=%b want %b 0", i, moving, motion_pulse, (i < 4));
            end
        end
    endtask

    task automatic test_resettle();
        x_in = 4'd7;
        step();
        step();
        n_cmp++;
        if (motion_pulse !== 1'b1) begin
            n_bad++;
            $display("FAIL resettle_pulse: got %b want 1", motion_pulse);
        end
        step();                       // SETTLING, cnt = 1
        x_in = 4'd8;
        step();                       // cnt = 2, x_q now 8
        step();                       // change seen in SETTLING -> MOVING
        n_cmp++;
        if (moving !== 1'b1 || motion_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL resettle_back: got mv=%b mp=%b want 1 0", moving, motion_pulse);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            n_cmp++;
            if (moving !== (i < 4) || motion_pulse !== 1'b0) begin
                n_bad++;
                $display("FAIL resettle[%0d]: got mv=%b mp=%b want %b 0", i, moving, motion_pulse, (i < 4));
            end
        end
    endtask

    task automatic test_press();
        x_in = 4'd7; y_in = 4'd2; btn_in = 3'b001;
        step();
        n_cmp++;
        if (ev_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL press_latency: got valid=%b want 0", ev_valid);
        end
        step();
        n_cmp++;
        if (ev_valid !== 1'b1 || ev_x !== 4'd7 || ev_y !== 4'd2 || ev_btn !== 3'b001 || ev_count !== 4'd1) begin
            n_bad++;
            $display("FAIL press_entry: got v=%b x=%0d y=%0d b=%b cnt=%0d want 1 7 2 001 1",
                     ev_valid, ev_x, ev_y, ev_btn, ev_count);
        end
        step(); step();
        btn_in = 3'b000;
        step(); step(); step();
        n_cmp++;
        if (ev_count !== 4'd1) begin
            n_bad++;
            $display("FAIL hold_release_count: got %0d want 1", ev_count);
        end
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        n_cmp++;
        if (ev_count !== 4'd0 || ev_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL press_pop: got cnt=%0d v=%b want 0 0", ev_count, ev_valid);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) begin
            x_in = 4'(i); y_in = 4'(15 - i); btn_in = 3'b001;
            step();
            btn_in = 3'b000;
            step();
        end
        n_cmp++;
        if (ev_count !== 4'd8 || overflow !== 1'b1 || ev_x !== 4'd0 || ev_y !== 4'd15) begin
            n_bad++;
            $display("FAIL overflow_full: got cnt=%0d ov=%b x=%0d y=%0d want 8 1 0 15",
                     ev_count, overflow, ev_x, ev_y);
        end
        // Push and pop on the same edge while full.
        x_in = 4'd12; y_in = 4'd9; btn_in = 3'b010;
        step();
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0; btn_in = 3'b000;
        n_cmp++;
        if (ev_count !== 4'd8 || overflow !== 1'b1 || ev_x !== 4'd1) begin
            n_bad++;
            $display("FAIL full_push_pop: got cnt=%0d ov=%b x=%0d want 8 1 1", ev_count, overflow, ev_x);
        end
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_overflow: got %b want 0", overflow);
        end
        ev_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            n_cmp++;
            if (ev_x !== 4'(i) || ev_y !== 4'(15 - i) || ev_btn !== 3'b001) begin
                n_bad++;
                $display("FAIL drain[%0d]: got x=%0d y=%0d b=%b want %0d %0d 001",
                         i, ev_x, ev_y, ev_btn, i, 15 - i);
            end
            step();
        end
        n_cmp++;
        if (ev_x !== 4'd12 || ev_y !== 4'd9 || ev_btn !== 3'b010 || ev_count !== 4'd1) begin
            n_bad++;
            $display("FAIL drain_last: got x=%0d y=%0d b=%b cnt=%0d want 12 9 010 1",
                     ev_x, ev_y, ev_btn, ev_count);
        end
        step();
        ev_ready = 1'b0;
        n_cmp++;
        if (ev_valid !== 1'b0 || ev_count !== 4'd0) begin
            n_bad++;
            $display("FAIL drain_empty: got v=%b cnt=%0d want 0 0", ev_valid, ev_count);
        end
    endtask

    task automatic test_multi_and_reset();
        x_in = 4'd3; y_in = 4'd4; btn_in = 3'b101;
        step(); step();
        n_cmp++;
        if (ev_btn !== 3'b101 || ev_x !== 4'd3 || ev_y !== 4'd4 || ev_count !== 4'd1) begin
            n_bad++;
            $display("FAIL multi_press: got b=%b x=%0d y=%0d cnt=%0d want 101 3 4 1",
                     ev_btn, ev_x, ev_y, ev_count);
        end
        btn_in = 3'b000; step();
        btn_in = 3'b001; step();
        btn_in = 3'b000; step();
        btn_in = 3'b010; step();
        btn_in = 3'b000; step();
        n_cmp++;
        if (ev_count !== 4'd3) begin
            n_bad++;
            $display("FAIL three_entries: got %0d want 3", ev_count);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (ev_valid !== 1'b0 || ev_count !== 4'd0 || moving !== 1'b0 || ev_x !== 4'd0) begin
            n_bad++;
            $display("FAIL midop_reset: got v=%b cnt=%0d mv=%b x=%0d want 0 0 0 0",
                     ev_valid, ev_count, moving, ev_x);
        end
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (motion_pulse !== 1'b0 || ev_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL reprime[%0d]: got mp=%b v=%b want 0 0", i, motion_pulse, ev_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_motion();
        test_resettle();
        test_press();
        test_overflow();
        test_multi_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
